// File: rtl/vendas_pkg.sv
// Shared types and constants for the vending-machine sequencer.
package vendas_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    CONSULTA,
    PAGAMENTO,
    DISPENSA,
    DEVOLVE
  } estado_t;

  localparam int         CRED_W         = 4;
  localparam logic [1:0] MOEDA_INVALIDA = 2'd0;

endpackage

// File: rtl/temporizador_inatividade.sv
// Idle timer for the payment phase: counts enabled cycles since the last clear and
// saturates at the terminal count instead of wrapping.
module temporizador_inatividade #(
  parameter int TIMEOUT_CIC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int         W  = $clog2(TIMEOUT_CIC + 1);
  localparam logic [W-1:0] TC = W'(TIMEOUT_CIC - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem <= '0;
    end else if (clear) begin
      contagem <= '0;
    end else if (enable && (contagem != TC)) begin
      contagem <= contagem + W'(1);
    end
  end

  assign expired = (contagem == TC);

endmodule

// File: rtl/controle_vendas.sv
// Vending-machine sequencer: selection lookup, coin collection, dispense handshake
// and change/refund payout one unit per cycle.
//
//   state     | meaning
//   OCIOSO    | idle, waiting for a selection
//   CONSULTA  | selector output settling, decide valid / invalid product
//   PAGAMENTO | collecting coins until price is met, cancel or timeout
//   DISPENSA  | dispensa_req held until dispensa_ack
//   DEVOLVE   | one troco_pulso per cycle until troco is paid out
module controle_vendas
  import vendas_pkg::*;
#(
  parameter int MAX_CREDITO = 9,
  parameter int TIMEOUT_CIC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              botao_sel,
  input  logic [1:0]        linha,
  input  logic [1:0]        coluna,
  input  logic              moeda_valida,
  input  logic [1:0]        moeda,
  input  logic              cancelar,
  output logic [1:0]        sel_linha,
  output logic [1:0]        sel_coluna,
  input  logic [2:0]        sel_valor,
  input  logic [3:0]        sel_codigo,
  input  logic              sel_existe,
  output logic              dispensa_req,
  input  logic              dispensa_ack,
  output logic [3:0]        codigo_disp,
  output logic              troco_pulso,
  output logic              moeda_rej,
  output logic              erro_sel,
  output logic [CRED_W-1:0] credito,
  output logic              ocupado
);

  localparam logic [CRED_W:0] MAX_C = (CRED_W + 1)'(MAX_CREDITO);

  estado_t           estado;
  logic [CRED_W-1:0] preco;
  logic [3:0]        codigo;
  logic [CRED_W-1:0] troco;
  logic [CRED_W:0]   soma;
  logic [CRED_W:0]   diferenca;
  logic [CRED_W-1:0] credito_novo;
  logic [CRED_W-1:0] sobra;
  logic              moeda_aceita;
  logic              expirou;

  always_comb begin
    soma         = {1'b0, credito} + (CRED_W + 1)'(moeda);
    moeda_aceita = (estado == PAGAMENTO) && moeda_valida &&
                   (moeda != MOEDA_INVALIDA) && (soma <= MAX_C);
    credito_novo = moeda_aceita ? soma[CRED_W-1:0] : credito;
    // change is clamped at zero so a short credit can never underflow
    diferenca    = {1'b0, credito} - {1'b0, preco};
    sobra        = (credito >= preco) ? diferenca[CRED_W-1:0] : '0;
  end

  temporizador_inatividade #(
    .TIMEOUT_CIC(TIMEOUT_CIC)
  ) u_temporizador (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((estado != PAGAMENTO) || moeda_aceita),
    .enable (estado == PAGAMENTO),
    .expired(expirou)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= OCIOSO;
      sel_linha  <= '0;
      sel_coluna <= '0;
      preco      <= '0;
      codigo     <= '0;
      credito    <= '0;
      troco      <= '0;
      moeda_rej  <= 1'b0;
      erro_sel   <= 1'b0;
    end else begin
      moeda_rej <= moeda_valida && !moeda_aceita;
      erro_sel  <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (botao_sel) begin
            sel_linha  <= linha;
            sel_coluna <= coluna;
            estado     <= CONSULTA;
          end
        end
        CONSULTA: begin
          if (sel_existe) begin
            preco  <= CRED_W'(sel_valor);
            codigo <= sel_codigo;
            estado <= PAGAMENTO;
          end else begin
            erro_sel <= 1'b1;
            estado   <= OCIOSO;
          end
        end
        PAGAMENTO: begin
          credito <= credito_novo;
          if (credito >= preco) begin
            estado <= DISPENSA;
          end else if (cancelar || expirou) begin
            // a coin accepted in the same cycle is part of the refund
            troco   <= credito_novo;
            credito <= '0;
            estado  <= (credito_novo == '0) ? OCIOSO : DEVOLVE;
          end
        end
        DISPENSA: begin
          if (dispensa_ack) begin
            troco   <= sobra;
            credito <= '0;
            estado  <= (sobra == '0) ? OCIOSO : DEVOLVE;
          end
        end
        DEVOLVE: begin
          troco <= troco - CRED_W'(1);
          if (troco <= CRED_W'(1)) begin
            estado <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign ocupado      = (estado != OCIOSO);
  assign dispensa_req = (estado == DISPENSA);
  assign troco_pulso  = (estado == DEVOLVE);
  assign codigo_disp  = codigo;

endmodule

// File: tb/tb_controle_vendas.sv
// Directed bench for controle_vendas with a small table model of the product selector.
module tb_controle_vendas;

  logic       clk;
  logic       rst_n;
  logic       botao_sel;
  logic [1:0] linha;
  logic [1:0] coluna;
  logic       moeda_valida;
  logic [1:0] moeda;
  logic       cancelar;
  logic [1:0] sel_linha;
  logic [1:0] sel_coluna;
  logic [2:0] sel_valor;
  logic [3:0] sel_codigo;
  logic       sel_existe;
  logic       dispensa_req;
  logic       dispensa_ack;
  logic [3:0] codigo_disp;
  logic       troco_pulso;
  logic       moeda_rej;
  logic       erro_sel;
  logic [3:0] credito;
  logic       ocupado;

  int n_comp = 0;
  int n_err  = 0;
  int pulsos;
  int disps;

  controle_vendas #(
    .MAX_CREDITO(9),
    .TIMEOUT_CIC(1000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .botao_sel   (botao_sel),
    .linha       (linha),
    .coluna      (coluna),
    .moeda_valida(moeda_valida),
    .moeda       (moeda),
    .cancelar    (cancelar),
    .sel_linha   (sel_linha),
    .sel_coluna  (sel_coluna),
    .sel_valor   (sel_valor),
    .sel_codigo  (sel_codigo),
    .sel_existe  (sel_existe),
    .dispensa_req(dispensa_req),
    .dispensa_ack(dispensa_ack),
    .codigo_disp (codigo_disp),
    .troco_pulso (troco_pulso),
    .moeda_rej   (moeda_rej),
    .erro_sel    (erro_sel),
    .credito     (credito),
    .ocupado     (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // product selector: (0,0) price 2, (1,0) price 6, (2,2) price 5, all else absent
  always_comb begin
    sel_existe = 1'b0;
    sel_valor  = 3'd0;
    sel_codigo = 4'd0;
    case ({sel_linha, sel_coluna})
      4'b00_00: begin sel_existe = 1'b1; sel_valor = 3'd2; sel_codigo = 4'b0001; end
      4'b01_00: begin sel_existe = 1'b1; sel_valor = 3'd6; sel_codigo = 4'b0100; end
      4'b10_10: begin sel_existe = 1'b1; sel_valor = 3'd5; sel_codigo = 4'b1010; end
      default: ;
    endcase
  end

  task automatic verifica(input string tag, input int obs, input int esp);
    n_comp++;
    if (obs != esp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic selecionar(input logic [1:0] l, input logic [1:0] c);
    botao_sel = 1'b1;
    linha     = l;
    coluna    = c;
    tick();
    botao_sel = 1'b0;
    tick();
  endtask

  task automatic inserir(input logic [1:0] m, input logic canc);
    moeda_valida = 1'b1;
    moeda        = m;
    cancelar     = canc;
    tick();
    moeda_valida = 1'b0;
    moeda        = 2'd0;
    cancelar     = 1'b0;
  endtask

  task automatic reconhecer();
    dispensa_ack = 1'b1;
    tick();
    dispensa_ack = 1'b0;
  endtask

  task automatic contar(input int ciclos, output int np, output int nd);
    np = 0;
    nd = 0;
    repeat (ciclos) begin
      np += int'(troco_pulso);
      nd += int'(dispensa_req);
      tick();
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    botao_sel    = 1'b0;
    linha        = 2'd0;
    coluna       = 2'd0;
    moeda_valida = 1'b0;
    moeda        = 2'd0;
    cancelar     = 1'b0;
    dispensa_ack = 1'b0;
    repeat (2) tick();

    verifica("rst_ocupado", int'(ocupado), 0);
    verifica("rst_credito", int'(credito), 0);
    verifica("rst_outputs", int'({dispensa_req, troco_pulso, moeda_rej, erro_sel}), 0);
    verifica("rst_codigo", int'(codigo_disp), 0);
    rst_n = 1'b1;
    tick();

    // coin while idle is returned
    inserir(2'd1, 1'b0);
    verifica("idle_coin_rej", int'(moeda_rej), 1);
    verifica("idle_coin_cred", int'(credito), 0);
    tick();

    // exact payment, no change
    selecionar(2'd1, 2'd0);
    verifica("t1_ocupado", int'(ocupado), 1);
    inserir(2'd3, 1'b0);
    inserir(2'd3, 1'b0);
    verifica("t1_credito", int'(credito), 6);
    verifica("t1_req_early", int'(dispensa_req), 0);
    tick();
    verifica("t1_req", int'(dispensa_req), 1);
    verifica("t1_codigo", int'(codigo_disp), 4);
    reconhecer();
    verifica("t1_req_drop", int'(dispensa_req), 0);
    verifica("t1_ocioso", int'(ocupado), 0);
    contar(5, pulsos, disps);
    verifica("t1_pulsos", pulsos, 0);

    // overpay by one unit
    selecionar(2'd2, 2'd2);
    inserir(2'd3, 1'b0);
    inserir(2'd3, 1'b0);
    tick();
    verifica("t2_codigo", int'(codigo_disp), 10);
    verifica("t2_req", int'(dispensa_req), 1);
    reconhecer();
    verifica("t2_credito", int'(credito), 0);
    contar(5, pulsos, disps);
    verifica("t2_pulsos", pulsos, 1);
    verifica("t2_ocioso", int'(ocupado), 0);

    // nonexistent product
    botao_sel = 1'b1;
    linha     = 2'd0;
    coluna    = 2'd1;
    tick();
    botao_sel = 1'b0;
    verifica("t3_erro_early", int'(erro_sel), 0);
    tick();
    verifica("t3_erro", int'(erro_sel), 1);
    verifica("t3_ocupado", int'(ocupado), 0);
    tick();
    verifica("t3_erro_pulse", int'(erro_sel), 0);
    verifica("t3_ocupado_next", int'(ocupado), 0);

    // cancel in the same cycle as the second coin
    selecionar(2'd0, 2'd0);
    inserir(2'd1, 1'b0);
    verifica("t4_credito", int'(credito), 1);
    inserir(2'd1, 1'b1);
    verifica("t4_credito_zero", int'(credito), 0);
    contar(6, pulsos, disps);
    verifica("t4_pulsos", pulsos, 2);
    verifica("t4_no_dispense", disps, 0);

    // invalid coin and coin that would overflow the credit ceiling
    selecionar(2'd1, 2'd0);
    inserir(2'd0, 1'b0);
    verifica("t5_rej_invalid", int'(moeda_rej), 1);
    verifica("t5_cred_invalid", int'(credito), 0);
    inserir(2'd3, 1'b0);
    inserir(2'd2, 1'b0);
    inserir(2'd3, 1'b0);
    verifica("t5_credito8", int'(credito), 8);
    inserir(2'd2, 1'b0);
    verifica("t5_rej_max", int'(moeda_rej), 1);
    verifica("t5_cred_max", int'(credito), 8);
    verifica("t5_req", int'(dispensa_req), 1);
    reconhecer();
    contar(6, pulsos, disps);
    verifica("t5_pulsos", pulsos, 2);

    // inactivity timeout refunds the credit
    selecionar(2'd0, 2'd0);
    inserir(2'd1, 1'b0);
    repeat (999) tick();
    verifica("t6_pre_timeout", int'(troco_pulso), 0);
    verifica("t6_still_busy", int'(ocupado), 1);
    tick();
    verifica("t6_timeout", int'(troco_pulso), 1);
    verifica("t6_credito", int'(credito), 0);
    tick();
    verifica("t6_ocioso", int'(ocupado), 0);

    // reset while paying out a refund of 3
    selecionar(2'd0, 2'd0);
    inserir(2'd3, 1'b1);
    verifica("t7_devolve", int'(troco_pulso), 1);
    rst_n = 1'b0;
    #1;
    verifica("t7_pulse_stop", int'(troco_pulso), 0);
    verifica("t7_ocupado", int'(ocupado), 0);
    verifica("t7_outputs", int'({dispensa_req, moeda_rej, erro_sel, credito, codigo_disp}), 0);
    #2;
    rst_n = 1'b1;
    contar(4, pulsos, disps);
    verifica("t7_no_resume", pulsos, 0);
    verifica("t7_idle", int'(ocupado), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
    $finish;
  end

endmodule
